decode_regfile: RTL and testbench

Parametrised decode stage with integrated register file for the Pillar core. It classifies the instruction word into RV32I formats R/I/S/U/B/J and reads two source operands from an NREGS-entry register file. It generates a sign-extended immediate and presents everything through a one-entry registered output with valid/ready handshakes. It sits between fetch (IR) and the ALU/execute stage and takes a single write-back port from the end of the pipeline.

---
 rtl/decode_regfile_if.sv | 35 +++
 rtl/decode_regfile.sv | 167 ++++++++++++++++
 tb/tb_decode_regfile.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_regfile_if.sv
`default_nettype none
// ============================================================================
// decode_regfile_if : fetch/write-back/execute handshake bundle for decode_regfile
// Revision: 1.0
// ============================================================================
interface decode_regfile_if #(
  parameter int XLEN = 32
);
  logic [31:0]     ir_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic            flush_i;
  logic            wr_en_i;
  logic [4:0]      wr_addr_i;
  logic [XLEN-1:0] wr_data_i;
  logic [XLEN-1:0] ra_o;
  logic [XLEN-1:0] rb_o;
  logic [XLEN-1:0] imm_o;
  logic [4:0]      rd_o;
  logic [4:0]      itype_o;
  logic            illegal_o;
  logic            out_valid_o;
  logic            out_ready_i;

  modport master (
    output ir_i, in_valid_i, flush_i, wr_en_i, wr_addr_i, wr_data_i, out_ready_i,
    input  in_ready_o, ra_o, rb_o, imm_o, rd_o, itype_o, illegal_o, out_valid_o
  );

  modport slave (
    input  ir_i, in_valid_i, flush_i, wr_en_i, wr_addr_i, wr_data_i, out_ready_i,
    output in_ready_o, ra_o, rb_o, imm_o, rd_o, itype_o, illegal_o, out_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
// decode_regfile : RV32I format decode, NREGS-entry register file and a
//                  one-entry registered output. Option macro: DECODE_BYPASS_EN
// Revision: 1.0
// ============================================================================
module decode_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  decode_regfile_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  localparam logic [4:0] FMT_NONE = 5'd0;
  localparam logic [4:0] FMT_R    = 5'd1;
  localparam logic [4:0] FMT_I    = 5'd2;
  localparam logic [4:0] FMT_S    = 5'd3;
  localparam logic [4:0] FMT_U    = 5'd4;
  localparam logic [4:0] FMT_B    = 5'd5;
  localparam logic [4:0] FMT_J    = 5'd6;

  logic [XLEN-1:0] regs [NREGS];
  logic [31:0]     ir;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            wr_ok;
  logic            capture;
  logic [4:0]      fmt;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] ra_next;
  logic [XLEN-1:0] rb_next;
  logic [4:0]      rd_next;

  logic            out_valid;
  logic [XLEN-1:0] ra_q;
  logic [XLEN-1:0] rb_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rd_q;
  logic [4:0]      itype_q;
  logic            illegal_q;

  assign ir    = bus.ir_i;
  assign rs1   = ir[19:15];
  assign rs2   = ir[24:20];
  assign wr_ok = bus.wr_en_i && (bus.wr_addr_i != 5'd0) && (int'(bus.wr_addr_i) < NREGS);

  always_comb begin
    fmt = FMT_NONE;
    case (ir[6:0])
      7'b0110011:                         fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                         fmt = FMT_S;
      7'b0110111, 7'b0010111:             fmt = FMT_U;
      7'b1100011:                         fmt = FMT_B;
      7'b1101111:                         fmt = FMT_J;
      default:                            fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
      FMT_S:   imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      FMT_B:   imm = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      FMT_U:   imm = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};
      FMT_J:   imm = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Out-of-range indices read zero rather than aliasing onto a truncated index.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if ((rs1 != 5'd0) && (int'(rs1) < NREGS)) begin
      rs1_val = regs[rs1[AW-1:0]];
`ifdef DECODE_BYPASS_EN
      if (wr_ok && (bus.wr_addr_i == rs1)) rs1_val = bus.wr_data_i;
`endif
    end
    if ((rs2 != 5'd0) && (int'(rs2) < NREGS)) begin
      rs2_val = regs[rs2[AW-1:0]];
`ifdef DECODE_BYPASS_EN
      if (wr_ok && (bus.wr_addr_i == rs2)) rs2_val = bus.wr_data_i;
`endif
    end
  end

  always_comb begin
    ra_next = '0;
    rb_next = '0;
    rd_next = 5'd0;
    case (fmt)
      FMT_R: begin
        ra_next = rs1_val;
        rb_next = rs2_val;
        rd_next = ir[11:7];
      end
      FMT_I: begin
        ra_next = rs1_val;
        rb_next = imm;
        rd_next = ir[11:7];
      end
      FMT_S, FMT_B: begin
        ra_next = rs1_val;
        rb_next = rs2_val;
      end
      FMT_U, FMT_J: begin
        rb_next = imm;
        rd_next = ir[11:7];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr_i[AW-1:0]] <= bus.wr_data_i;
    end
  end

  assign bus.in_ready_o = !out_valid || bus.out_ready_i;
  assign capture        = bus.in_valid_i && bus.in_ready_o;

  // Flush wins over a same-edge capture; data is only loaded on capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      ra_q      <= '0;
      rb_q      <= '0;
      imm_q     <= '0;
      rd_q      <= 5'd0;
      itype_q   <= FMT_NONE;
      illegal_q <= 1'b0;
    end else if (bus.flush_i) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      ra_q      <= ra_next;
      rb_q      <= rb_next;
      imm_q     <= imm;
      rd_q      <= rd_next;
      itype_q   <= fmt;
      illegal_q <= (fmt == FMT_NONE);
    end else if (bus.out_ready_i) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid_o = out_valid;
  assign bus.ra_o        = ra_q;
  assign bus.rb_o        = rb_q;
  assign bus.imm_o       = imm_q;
  assign bus.rd_o        = rd_q;
  assign bus.itype_o     = itype_q;
  assign bus.illegal_o   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_regfile.sv
`default_nettype none
// ============================================================================
// tb_decode_regfile : directed and random checks of decode_regfile against a
//                     spec-level reference model. Revision: 1.0
// ============================================================================
module tb_decode_regfile;
  localparam int NREGS = 16;
`ifdef DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  itype;
    logic        ill;
  } dec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mreg [32];
  dec_t        want;
  logic        exp_valid;
  logic        clean;

  decode_regfile_if #(.XLEN(32)) bus ();

  decode_regfile #(.XLEN(32), .NREGS(NREGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] val, input int bits);
    logic [31:0] m;
    m = 32'd1 << (bits - 1);
    return (val ^ m) - m;
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] idx, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0 || int'(idx) >= NREGS) return 32'd0;
    if (BYPASS && we && wa == idx) return wd;
    return mreg[idx];
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] ir, input logic we,
                                      input logic [4:0] wa, input logic [31:0] wd);
    dec_t d;
    logic [31:0] v1, v2;
    d  = '0;
    v1 = rd_model(ir[19:15], we, wa, wd);
    v2 = rd_model(ir[24:20], we, wa, wd);
    case (ir[6:0])
      7'h33: begin d.itype = 5'd1; d.ra = v1; d.rb = v2; d.rd = ir[11:7]; end
      7'h13, 7'h03, 7'h67: begin
        d.itype = 5'd2; d.imm = sx(ir >> 20, 12);
        d.ra = v1; d.rb = d.imm; d.rd = ir[11:7];
      end
      7'h23: begin
        d.itype = 5'd3; d.imm = sx(((ir >> 25) << 5) | ((ir >> 7) & 32'd31), 12);
        d.ra = v1; d.rb = v2;
      end
      7'h37, 7'h17: begin
        d.itype = 5'd4; d.imm = ir & 32'hFFFF_F000; d.rb = d.imm; d.rd = ir[11:7];
      end
      7'h63: begin
        d.itype = 5'd5;
        d.imm = sx(((ir >> 31) << 12) | (((ir >> 7) & 32'd1) << 11) |
                   (((ir >> 25) & 32'd63) << 5) | (((ir >> 8) & 32'd15) << 1), 13);
        d.ra = v1; d.rb = v2;
      end
      7'h6F: begin
        d.itype = 5'd6;
        d.imm = sx(((ir >> 31) << 20) | (((ir >> 12) & 32'd255) << 12) |
                   (((ir >> 20) & 32'd1) << 11) | (((ir >> 21) & 32'd1023) << 1), 21);
        d.rb = d.imm; d.rd = ir[11:7];
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_ra"},    bus.ra_o,                want.ra);
    chk({tag, "_rb"},    bus.rb_o,                want.rb);
    chk({tag, "_imm"},   bus.imm_o,               want.imm);
    chk({tag, "_rd"},    32'(bus.rd_o),           32'(want.rd));
    chk({tag, "_itype"}, 32'(bus.itype_o),        32'(want.itype));
    chk({tag, "_ill"},   32'(bus.illegal_o),      32'(want.ill));
  endtask

  // Entered and left at posedge+1: drive, check in_ready, clock, check outputs.
  task automatic cycle(input logic iv, input logic [31:0] ir, input logic ordy, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    dec_t nd;
    logic cap;
    bus.in_valid_i  = iv;
    bus.ir_i        = ir;
    bus.out_ready_i = ordy;
    bus.flush_i     = fl;
    bus.wr_en_i     = we;
    bus.wr_addr_i   = wa;
    bus.wr_data_i   = wd;
    #1;
    chk("in_ready", 32'(bus.in_ready_o), 32'(!exp_valid || ordy));
    cap = iv && (!exp_valid || ordy);
    nd  = ref_decode(ir, we, wa, wd);
    @(posedge clk);
    if (fl) exp_valid = 1'b0;
    else if (cap) begin exp_valid = 1'b1; want = nd; clean = 1'b0; end
    else if (ordy) exp_valid = 1'b0;
    if (we && wa != 5'd0 && int'(wa) < NREGS) mreg[wa] = wd;
    #1;
    chk("out_valid", 32'(bus.out_valid_o), 32'(exp_valid));
    if (exp_valid || clean) check_outputs("out");
  endtask

  initial begin
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F};
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    want = '0; exp_valid = 1'b0; clean = 1'b1;
    bus.in_valid_i = 1'b0; bus.ir_i = 32'd0; bus.out_ready_i = 1'b0; bus.flush_i = 1'b0;
    bus.wr_en_i = 1'b0; bus.wr_addr_i = 5'd0; bus.wr_data_i = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("reset_in_ready",  32'(bus.in_ready_o),  32'd1);
    check_outputs("reset");
    reset = 1'b1;

    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_0010);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'hFFFF_FFF0);

    cycle(1'b1, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("add_valid", 32'(bus.out_valid_o), 32'd1);
    chk("add_ra", bus.ra_o, 32'h0000_0010);
    chk("add_rb", bus.rb_o, 32'hFFFF_FFF0);
    chk("add_rd", 32'(bus.rd_o), 32'd3);
    chk("add_itype", 32'(bus.itype_o), 32'd1);

    cycle(1'b1, 32'hFFF0_0093, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("addi_imm", bus.imm_o, 32'hFFFF_FFFF);
    chk("addi_rb", bus.rb_o, 32'hFFFF_FFFF);
    chk("addi_itype", 32'(bus.itype_o), 32'd2);

    cycle(1'b1, 32'h1234_52B7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("lui_imm", bus.imm_o, 32'h1234_5000);
    chk("lui_ra", bus.ra_o, 32'd0);
    chk("lui_itype", 32'(bus.itype_o), 32'd4);

    cycle(1'b1, 32'hFE11_2E23, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("sw_imm", bus.imm_o, 32'hFFFF_FFFC);
    chk("sw_itype", 32'(bus.itype_o), 32'd3);
    chk("sw_rd", 32'(bus.rd_o), 32'd0);

    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h1234_52B7, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("stall_in_ready", 32'(bus.in_ready_o), 32'd0);
    chk("stall_imm", bus.imm_o, 32'hFFFF_FFFC);
    chk("stall_valid", 32'(bus.out_valid_o), 32'd1);

    cycle(1'b1, 32'hFFF0_0093, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("flush_valid", 32'(bus.out_valid_o), 32'd0);

    cycle(1'b1, 32'h0020_81B3, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_00AA);
    chk("hazard_ra", bus.ra_o, BYPASS ? 32'h0000_00AA : 32'h0000_0010);
    cycle(1'b1, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("after_hazard_ra", bus.ra_o, 32'h0000_00AA);

    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_0055);
    cycle(1'b1, 32'h0000_01B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("x0_ra", bus.ra_o, 32'd0);

    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd20, 32'h0000_0077);
    cycle(1'b1, 32'h0140_01B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("x20_rb", bus.rb_o, 32'd0);
    cycle(1'b1, 32'h000A_01B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("x20_ra", bus.ra_o, 32'd0);

    cycle(1'b1, 32'h0000_007F, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("illegal_flag", 32'(bus.illegal_o), 32'd1);
    chk("illegal_itype", 32'(bus.itype_o), 32'd0);
    chk("illegal_rb", bus.rb_o, 32'd0);

    for (int n = 0; n < 400; n++) begin
      int k;
      logic [31:0] r;
      k = int'($urandom_range(0, 9));
      r = $urandom() & 32'hFFFF_FF80;
      r = r | ((k == 9) ? 32'($urandom_range(0, 127)) : 32'(ops[k]));
      cycle(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom());
    end

    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
    cycle(1'b1, 32'h0052_8333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("r5_ra", bus.ra_o, 32'h0000_1234);
    cycle(1'b1, 32'h0052_8333, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    want = '0; exp_valid = 1'b0; clean = 1'b1;
    chk("async_rst_valid", 32'(bus.out_valid_o), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b1, 32'h0052_8333, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("r5_after_rst", bus.ra_o, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
